// File: rtl/led_pkg.sv
// Shared defaults and small types for the LED PWM bank and its channel slices.
package led_pkg;

    localparam int BW_DEF   = 10;
    localparam int N_CH_DEF = 8;

    typedef logic [BW_DEF-1:0] level_t;
    typedef logic [3:0]        ch_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: holds the active level, loads it on the swap strobe and
// registers the compare (or full-on) result onto its LED pin.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [BW-1:0] load_level,
    input  logic [BW-1:0] pwm_ctr,
    output logic          led
);

    logic [BW-1:0] active_q;
    logic [BW-1:0] active_d;
    logic          led_q;
    logic          led_d;

    // All-ones must stay lit for the whole period, which a plain compare cannot do.
    always_comb begin
        active_d = load ? load_level : active_q;
        led_d    = (active_q == {BW{1'b1}}) ? 1'b1 : (pwm_ctr < active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            led_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel PWM driver: writes land in a shadow bank and a committed frame
// is copied to the active levels only at a PWM period boundary.
module led_pwm_bank
    import led_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int BW       = BW_DEF,
    parameter int PRESCALE = 1
) (
    input  logic            clk_16mhz,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_ch,
    input  logic [BW-1:0]   in_level,
    input  logic            in_last,
    output logic [N_CH-1:0] led,
    output logic            frame_sync,
    output logic            pending
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic [BW-1:0]   pwm_ctr_q;
    logic [BW-1:0]   pwm_ctr_d;
    logic            pending_q;
    logic            pending_d;
    logic            frame_sync_q;
    logic            frame_sync_d;
    logic [BW-1:0]   shadow_q [N_CH];
    logic [BW-1:0]   shadow_d [N_CH];

    logic tick;
    logic boundary;
    logic swap;
    logic accept;

    always_comb begin
        tick      = (ps_q == PS_LAST);
        ps_d      = tick ? '0 : ps_q + 1'b1;
        pwm_ctr_d = tick ? pwm_ctr_q + 1'b1 : pwm_ctr_q;
        boundary  = tick && (pwm_ctr_q == {BW{1'b1}});
        frame_sync_d = boundary;
    end

    // swap needs pending already set and accept needs it clear, so a commit
    // landing on a boundary always waits for the following one.
    always_comb begin
        swap      = boundary && pending_q;
        accept    = in_valid && !pending_q;
        pending_d = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end
        if (accept && in_last) begin
            pending_d = 1'b1;
        end
    end

    // Writes to channels beyond N_CH match no slot and simply vanish.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (accept && (in_ch == ch_t'(i))) begin
                shadow_d[i] = in_level;
            end
        end
    end

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            ps_q         <= '0;
            pwm_ctr_q    <= '0;
            pending_q    <= 1'b0;
            frame_sync_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            ps_q         <= ps_d;
            pwm_ctr_q    <= pwm_ctr_d;
            pending_q    <= pending_d;
            frame_sync_q <= frame_sync_d;
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_pwm_channel #(
            .BW(BW)
        ) u_ch (
            .clk        (clk_16mhz),
            .rst_n      (rst_n),
            .load       (swap),
            .load_level (shadow_q[g]),
            .pwm_ctr    (pwm_ctr_q),
            .led        (led[g])
        );
    end

    assign in_ready   = !pending_q;
    assign pending    = pending_q;
    assign frame_sync = frame_sync_q;

endmodule
